// File: rtl/osnt_sume_axi_sim_slave.sv
// AXI4-Lite register-bank responder with independent single-outstanding write and read channels.
// Optional macro AXI_SLAVE_WAIT_EN inserts WAIT_CYCLES of ready delay on both channels.
module osnt_sume_axi_sim_slave #(
   parameter int unsigned                  C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned                  C_S_AXI_ADDR_WIDTH = 32,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR        = '0,
   parameter int unsigned                  NUM_REGS           = 16,
   parameter int unsigned                  WAIT_CYCLES        = 2
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]            reg_out,
   output logic [NUM_REGS-1:0]               reg_wr_pulse
);

   localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW    = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned IDX_W = $clog2(NUM_REGS);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

`ifdef AXI_SLAVE_WAIT_EN
   localparam int unsigned WAIT_LEN = WAIT_CYCLES;
   localparam int unsigned CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`else
   // Wait insertion compiled out: behave exactly like a zero-length wait.
   localparam int unsigned WAIT_LEN = 0 * WAIT_CYCLES;
`endif

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_ACK, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ACK, R_DATA} rstate_t;

   wstate_t r_wstate, w_wstate_nxt;
   rstate_t r_rstate, w_rstate_nxt;

   logic [DW-1:0]       r_regs [NUM_REGS];
   logic                r_wready;
   logic                r_bvalid;
   logic [1:0]          r_bresp;
   logic                r_arready;
   logic                r_rvalid;
   logic [1:0]          r_rresp;
   logic [DW-1:0]       r_rdata;
   logic [NUM_REGS-1:0] r_wr_pulse;

   logic [AW-1:0]    w_woff, w_roff;
   logic             w_whit, w_rhit;
   logic [IDX_W-1:0] w_widx, w_ridx;

   // Address decode for both channels; low two address bits are don't-care.
   assign w_woff = S_AXI_AWADDR - C_BASEADDR;
   assign w_roff = S_AXI_ARADDR - C_BASEADDR;
   assign w_whit = (S_AXI_AWADDR >= C_BASEADDR) && (w_woff < AW'(4 * NUM_REGS));
   assign w_rhit = (S_AXI_ARADDR >= C_BASEADDR) && (w_roff < AW'(4 * NUM_REGS));
   assign w_widx = w_woff[IDX_W+1:2];
   assign w_ridx = w_roff[IDX_W+1:2];

`ifdef AXI_SLAVE_WAIT_EN
   logic [CNT_W-1:0] r_wcnt, r_rcnt;

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_wcnt <= '0;
         r_rcnt <= '0;
      end else begin
         r_wcnt <= (r_wstate == W_WAIT) ? r_wcnt + CNT_W'(1) : '0;
         r_rcnt <= (r_rstate == R_WAIT) ? r_rcnt + CNT_W'(1) : '0;
      end
   end
`endif

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
      end
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID)
                    w_wstate_nxt = (WAIT_LEN != 0) ? W_WAIT : W_ACK;
`ifdef AXI_SLAVE_WAIT_EN
         W_WAIT: if (r_wcnt == CNT_W'(WAIT_LEN - 1)) w_wstate_nxt = W_ACK;
`endif
         W_ACK:  w_wstate_nxt = W_RESP;
         W_RESP: if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE: if (S_AXI_ARVALID)
                    w_rstate_nxt = (WAIT_LEN != 0) ? R_WAIT : R_ACK;
`ifdef AXI_SLAVE_WAIT_EN
         R_WAIT: if (r_rcnt == CNT_W'(WAIT_LEN - 1)) w_rstate_nxt = R_ACK;
`endif
         R_ACK:  w_rstate_nxt = R_DATA;
         R_DATA: if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // Handshake outputs are registered copies of the upcoming state.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         r_wready  <= (w_wstate_nxt == W_ACK);
         r_bvalid  <= (w_wstate_nxt == W_RESP);
         r_arready <= (w_rstate_nxt == R_ACK);
         r_rvalid  <= (w_rstate_nxt == R_DATA);
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (r_wstate == W_ACK) begin
            r_bresp <= w_whit ? RESP_OKAY : RESP_SLVERR;
            if (w_whit) begin
               r_wr_pulse[w_widx] <= 1'b1;
               for (int b = 0; b < SW; b++)
                  if (S_AXI_WSTRB[b]) r_regs[w_widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
         end
      end
   end

   // Read data sampled from the pre-write contents when both channels close together.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (r_rstate == R_ACK) begin
         r_rdata <= w_rhit ? r_regs[w_ridx] : '0;
         r_rresp <= w_rhit ? RESP_OKAY : RESP_SLVERR;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_out[32*g +: 32] = r_regs[g];
   end

   assign S_AXI_AWREADY = r_wready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rdata;
   assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: doc/osnt_sume_axi_sim_slave.md
Name: osnt_sume_axi_sim_slave

Overview:
AXI4-Lite responder for simulation and for small on-chip register banks. It is the completer counterpart to the AXI-Lite sim master. It accepts single-beat write and read transactions, stores them in NUM_REGS 32-bit registers, and returns OKAY or SLVERR responses. The register contents are exported as a flat bus so that DUT logic and testbench checkers can observe programmed values.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 32, address width.
C_BASEADDR, 32'h0000_0000, byte address of register 0.
NUM_REGS, 16, number of 32-bit registers (2..256).
WAIT_CYCLES, 2, extra ready-delay cycles; used only with AXI_SLAVE_WAIT_EN.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  reset; asynchronous, active-high
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  NUM_REGS*32  register i is at [32*i+31:32*i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse; bit i set on the cycle register i is written

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all registers = 0;
  - AWREADY = WREADY = ARREADY = BVALID = RVALID = 0;
  - BRESP = RRESP = 2'b00; RDATA = 0; reg_wr_pulse = 0;
  - both FSMs go to IDLE and any in-flight transaction is dropped.
- Address decode:
  - off = ADDR - C_BASEADDR;
  - hit when ADDR >= C_BASEADDR and off < 4*NUM_REGS;
  - index = off[9:2]; ADDR[1:0] is ignored.
- Write FSM states: W_IDLE, W_WAIT, W_ACK, W_RESP.
  - W_IDLE: if AWVALID and WVALID are both sampled high, go to W_WAIT (macro on, WAIT_CYCLES>0) or W_ACK. AWVALID without WVALID (or the reverse) is held; nothing is accepted.
  - W_ACK: AWREADY and WREADY are high together for exactly one cycle. At the closing edge:
    - on a hit, byte lane b of register[index] is updated where WSTRB[b]=1, and reg_wr_pulse[index]=1 for the following cycle;
    - BRESP = 00 on a hit, 10 (SLVERR) on a miss; go to W_RESP.
  - W_RESP: BVALID=1 and held with a stable BRESP until BREADY is sampled high; then go to W_IDLE.
  - Minimum write latency (no wait): valids sampled at edge k → ready during cycle k+1 → BVALID from cycle k+2.
  - A write with WSTRB = 0 returns OKAY, leaves the register unchanged, and still pulses reg_wr_pulse.
- Read FSM states: R_IDLE, R_WAIT, R_ACK, R_DATA.
  - R_IDLE: ARVALID sampled high → R_WAIT or R_ACK.
  - R_ACK: ARREADY=1 for one cycle. At its edge, RDATA is captured = register[index] on a hit, 32'h0 with RRESP=10 on a miss.
  - R_DATA: RVALID=1; RDATA and RRESP held stable until RREADY is sampled high; then go to R_IDLE.
  - Minimum read latency: ARVALID at edge k → RVALID from cycle k+2.
- Channel independence and hazards:
  - The read and write FSMs are independent and may complete on the same edge.
  - If a read and a write to the same register complete on the same edge, the read returns the pre-write value.
- No outstanding transactions beyond one per channel: the slave accepts nothing new while BVALID or RVALID is high.
- Backpressure: BREADY or RREADY held low for any number of cycles is legal; no response may be lost or repeated.

Optional Feature:
Macro AXI_SLAVE_WAIT_EN.
- Defined: W_WAIT and R_WAIT each count WAIT_CYCLES cycles (counter of $clog2(WAIT_CYCLES+1) bits) before entering W_ACK/R_ACK. Latency to BVALID/RVALID becomes k+2+WAIT_CYCLES. WAIT_CYCLES=0 skips the wait state.
- Undefined: the wait states and counters are not compiled; behaviour matches WAIT_CYCLES=0.

Test Plan:
- Write 0x00000008, data 0xCAFEF00D, WSTRB 0xF → BRESP=00 at cycle k+2, reg_out[95:64]=0xCAFEF00D, reg_wr_pulse=0x0004 for one cycle; read 0x08 → RDATA=0xCAFEF00D, RRESP=00.
- Register 0 = 0x11223344; write 0xAABBCCDD with WSTRB 0x5 → read 0x00 returns 0x11BB33DD.
- Write and read 0x00000040 (NUM_REGS=16, out of range) → BRESP=10, RRESP=10, RDATA=0, reg_out unchanged.
- Hold BREADY/RREADY low for 10 cycles after the response is raised → BVALID/RVALID stay high with stable data; new AWVALID/ARVALID is not accepted until the handshake completes.
- Register 3 = 0x5; a read and a write of 0x9 to 0x0C accepted on the same edge → RDATA=0x5, then a subsequent read returns 0x9.
- Macro on, WAIT_CYCLES=2: write issued at edge k → AWREADY/WREADY high in cycle k+3, BVALID from k+4. Assert S_AXI_ARESET during W_WAIT → all outputs return to 0 immediately, registers are cleared, and the next write completes normally.
